// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the millisecond stopwatch: FSM states,
// per-digit maxima and the bit offsets of each BCD field in the display word.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_e;

    localparam logic [3:0] DigitMax9 = 4'd9;
    localparam logic [3:0] DigitMax5 = 4'd5;

    localparam int unsigned MsOnesLsb  = 0;
    localparam int unsigned MsTensLsb  = 4;
    localparam int unsigned MsHundLsb  = 8;
    localparam int unsigned SecOnesLsb = 12;
    localparam int unsigned SecTensLsb = 16;
    localparam int unsigned MinLsb     = 20;

endpackage

// File: rtl/stopwatch_ms_bcd_digit.sv
// One BCD digit counter that wraps at MAX and signals a carry to the next digit.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    logic at_max;

    assign at_max = (q == MAX);
    assign carry  = inc & at_max;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= at_max ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ms.sv
// Millisecond BCD stopwatch (0:00.000 .. 9:59.999) with start/stop/clear control.
// Optional lap-hold display capture is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ms
    import stopwatch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1khz,
    input  logic        start_stop,
    input  logic        clear,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap,
    output logic        lap_hold,
`endif
    output logic [23:0] bcd,
    output logic        running,
    output logic        ovf
);

    state_e state_q, state_d;

    logic        tick_prev;
    logic        tick_rise;
    logic        count_en;
    logic [5:0]  carry;
    logic [3:0]  ms_ones, ms_tens, ms_hund, sec_ones, sec_tens, minutes;
    logic [23:0] live;

    assign tick_rise = tick_1khz & ~tick_prev;
    // Only the state held at this edge decides whether a tick counts.
    assign count_en  = tick_rise & (state_q == StRun) & ~clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_prev <= 1'b1;
        end else begin
            tick_prev <= tick_1khz;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else if (start_stop) begin
            case (state_q)
                StIdle:  state_d = StRun;
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            running <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            running <= (state_d == StRun);
            ovf     <= carry[5];
        end
    end

    bcd_digit #(.MAX(DigitMax9)) u_ms_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (count_en),
        .q     (ms_ones),
        .carry (carry[0])
    );

    bcd_digit #(.MAX(DigitMax9)) u_ms_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (carry[0]),
        .q     (ms_tens),
        .carry (carry[1])
    );

    bcd_digit #(.MAX(DigitMax9)) u_ms_hund (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (carry[1]),
        .q     (ms_hund),
        .carry (carry[2])
    );

    bcd_digit #(.MAX(DigitMax9)) u_sec_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (carry[2]),
        .q     (sec_ones),
        .carry (carry[3])
    );

    bcd_digit #(.MAX(DigitMax5)) u_sec_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (carry[3]),
        .q     (sec_tens),
        .carry (carry[4])
    );

    bcd_digit #(.MAX(DigitMax9)) u_min (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (carry[4]),
        .q     (minutes),
        .carry (carry[5])
    );

    always_comb begin
        live = 24'h000000;
        live[MsOnesLsb  +: 4] = ms_ones;
        live[MsTensLsb  +: 4] = ms_tens;
        live[MsHundLsb  +: 4] = ms_hund;
        live[SecOnesLsb +: 4] = sec_ones;
        live[SecTensLsb +: 4] = sec_tens;
        live[MinLsb     +: 4] = minutes;
    end

`ifdef STOPWATCH_LAP_EN
    logic [23:0] lap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_hold <= 1'b0;
            lap_q    <= 24'h000000;
        end else if (clear) begin
            lap_hold <= 1'b0;
        end else if (lap && (state_q != StIdle)) begin
            if (lap_hold) begin
                lap_hold <= 1'b0;
            end else begin
                lap_hold <= 1'b1;
                lap_q    <= live;
            end
        end
    end

    assign bcd = lap_hold ? lap_q : live;
`else
    assign bcd = live;
`endif

endmodule

// File: tb/tb_stopwatch_ms.sv
// Self-checking bench for stopwatch_ms: directed scenarios plus a randomized phase,
// compared every cycle against a millisecond-count reference model.
module tb_stopwatch_ms;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1khz = 1'b1;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] bcd;
    logic        running;
    logic        ovf;
`ifdef STOPWATCH_LAP_EN
    logic        lap = 1'b0;
    logic        lap_hold;
    logic        lap_r = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: elapsed milliseconds and a run mode.
    localparam int ModeIdle = 0, ModeRun = 1, ModePause = 2;
    int   m_ms   = 0;
    int   m_mode = ModeIdle;
    logic m_prev = 1'b1;
    logic m_ovf  = 1'b0;
    logic m_hold = 1'b0;
    int   m_cap  = 0;

    logic [23:0] preload_v;

    always #20 clk = ~clk;

    stopwatch_ms dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1khz  (tick_1khz),
        .start_stop (start_stop),
        .clear      (clear),
`ifdef STOPWATCH_LAP_EN
        .lap        (lap),
        .lap_hold   (lap_hold),
`endif
        .bcd        (bcd),
        .running    (running),
        .ovf        (ovf)
    );

    function automatic logic [23:0] to_bcd(input int ms);
        int mn, s, r;
        mn = ms / 60000;
        s  = (ms / 1000) % 60;
        r  = ms % 1000;
        return {4'(mn), 4'(s / 10), 4'(s % 10), 4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic t, input logic ss, input logic cl);
        logic rise;
        logic [23:0] exp_bcd;
        rst        = r;
        tick_1khz  = t;
        start_stop = ss;
        clear      = cl;
`ifdef STOPWATCH_LAP_EN
        lap = lap_r;
`endif
        @(posedge clk);
        rise  = t & ~m_prev;
        m_ovf = 1'b0;
        if (r) begin
            m_ms = 0; m_mode = ModeIdle; m_prev = 1'b1; m_hold = 1'b0;
        end else begin
            m_prev = t;
            if (cl) begin
                m_ms = 0; m_mode = ModeIdle; m_hold = 1'b0;
            end else begin
`ifdef STOPWATCH_LAP_EN
                if (lap_r && m_mode != ModeIdle) begin
                    if (m_hold) m_hold = 1'b0;
                    else begin m_hold = 1'b1; m_cap = m_ms; end
                end
`endif
                if (rise && m_mode == ModeRun) begin
                    if (m_ms == 599999) begin m_ms = 0; m_ovf = 1'b1; end
                    else m_ms++;
                end
                if (ss) m_mode = (m_mode == ModeRun) ? ModePause : ModeRun;
            end
        end
`ifdef STOPWATCH_LAP_EN
        lap_r = 1'b0;
`endif
        #1;
        exp_bcd = m_hold ? to_bcd(m_cap) : to_bcd(m_ms);
        check("bcd", 32'(bcd), 32'(exp_bcd));
        check("running", 32'(running), 32'(m_mode == ModeRun));
        check("ovf", 32'(ovf), 32'(m_ovf));
`ifdef STOPWATCH_LAP_EN
        check("lap_hold", 32'(lap_hold), 32'(m_hold));
`endif
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Jump the digit registers to a given count while the stopwatch is quiet.
    task automatic preload(input int ms);
        preload_v = to_bcd(ms);
        force dut.u_ms_ones.q  = preload_v[3:0];
        force dut.u_ms_tens.q  = preload_v[7:4];
        force dut.u_ms_hund.q  = preload_v[11:8];
        force dut.u_sec_ones.q = preload_v[15:12];
        force dut.u_sec_tens.q = preload_v[19:16];
        force dut.u_min.q      = preload_v[23:20];
        #1;
        release dut.u_ms_ones.q;
        release dut.u_ms_tens.q;
        release dut.u_ms_hund.q;
        release dut.u_sec_ones.q;
        release dut.u_sec_tens.q;
        release dut.u_min.q;
        m_ms = ms;
    endtask

    initial begin
        logic t, ss, cl, r;

        // Reset with the tick held high, then no edge until it drops and rises.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("no_spurious_tick", 32'(bcd), 32'h0);

        tick_n(1234);
        check("count_1234", 32'(bcd), 32'h001234);
        check("run_1234", 32'(running), 32'h1);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tick_n(500);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tick_n(10);
        check("pause_hold", 32'(bcd), 32'h000500);
        check("pause_running", 32'(running), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tick_n(3);
        check("resume_503", 32'(bcd), 32'h000503);

        // Tick with RUN->PAUSE counts; tick with PAUSE->RUN is dropped.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("tick_at_pause", 32'(bcd), 32'h000504);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("tick_at_resume", 32'(bcd), 32'h000504);
        check("resumed", 32'(running), 32'h1);

        // clear beats start_stop and tick in the same cycle.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tick_n(42);
        check("count_42", 32'(bcd), 32'h000042);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("clear_prio_bcd", 32'(bcd), 32'h0);
        check("clear_prio_run", 32'(running), 32'h0);

`ifdef STOPWATCH_LAP_EN
        lap_r = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("lap_idle_ignored", 32'(lap_hold), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tick_n(100);
        lap_r = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tick_n(50);
        check("lap_bcd", 32'(bcd), 32'h000100);
        check("lap_hold_on", 32'(lap_hold), 32'h1);
        lap_r = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("lap_release_bcd", 32'(bcd), 32'h000150);
        check("lap_hold_off", 32'(lap_hold), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Minute carry and full wrap, starting from preloaded counts.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        preload(59998);
        tick_n(2);
        check("minute_carry", 32'(bcd), 32'h100000);
        preload(599995);
        tick_n(4);
        check("at_max", 32'(bcd), 32'h959999);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("wrap_bcd", 32'(bcd), 32'h0);
        check("wrap_ovf", 32'(ovf), 32'h1);
        check("wrap_running", 32'(running), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_one_cycle", 32'(ovf), 32'h0);

        // Randomized control and tick traffic.
        for (int i = 0; i < 4000; i++) begin
            t  = m_prev ? 1'b0 : 1'($urandom_range(0, 1));
            ss = ($urandom_range(0, 7) == 0);
            cl = ($urandom_range(0, 63) == 0);
            r  = ($urandom_range(0, 499) == 0);
`ifdef STOPWATCH_LAP_EN
            lap_r = ($urandom_range(0, 15) == 0);
`endif
            step(r, t, ss, cl);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
